// File: rtl/cpu_regfile_mp.sv
// Multi-port register file: two registered read ports and one write port
// that can load, increment, decrement or clear a register, with a wrap pulse.
module cpu_regfile_mp #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    output logic              wrap
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              wr_hit_c;
    logic              wr_commit_c;
    logic [DATA_W-1:0] old_val_c;
    logic [DATA_W-1:0] new_val_c;
    logic [DATA_W-1:0] stored_a_c;
    logic [DATA_W-1:0] stored_b_c;
    logic              wrap_c;
    logic              byp_a_c;
    logic              byp_b_c;

    // Address decode; out-of-range indices match no entry and read as 0.
    always_comb begin
        wr_hit_c   = 1'b0;
        old_val_c  = '0;
        stored_a_c = '0;
        stored_b_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                wr_hit_c  = 1'b1;
                old_val_c = regs[i];
            end
            if (rd_addr_a == ADDR_W'(i)) stored_a_c = regs[i];
            if (rd_addr_b == ADDR_W'(i)) stored_b_c = regs[i];
        end
    end

    // Write-port result computed from the stored value only.
    always_comb begin
        wr_commit_c = wr_en && wr_hit_c && !((ZERO_R0 != 0) && (wr_addr == '0));
        new_val_c   = '0;
        wrap_c      = 1'b0;
        case (wr_op)
            OP_LOAD: new_val_c = wr_data;
            OP_INC: begin
                new_val_c = old_val_c + DATA_W'(1);
                wrap_c    = wr_commit_c && (old_val_c == '1);
            end
            OP_DEC: begin
                new_val_c = old_val_c - DATA_W'(1);
                wrap_c    = wr_commit_c && (old_val_c == '0);
            end
            OP_CLR:  new_val_c = '0;
            default: new_val_c = '0;
        endcase
        byp_a_c = wr_commit_c && (rd_addr_a == wr_addr);
        byp_b_c = wr_commit_c && (rd_addr_b == wr_addr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_commit_c && (wr_addr == ADDR_W'(i))) regs[i] <= new_val_c;
            end
            wrap       <= wrap_c;
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= byp_a_c ? new_val_c : stored_a_c;
            if (rd_en_b) rd_data_b <= byp_b_c ? new_val_c : stored_b_c;
        end
    end

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Scoreboard bench for cpu_regfile_mp: a plain-array reference model predicts each
// cycle's outputs for two configurations driven by the same stimulus.
module tb_cpu_regfile_mp;

    typedef struct {
        logic       va;
        logic [7:0] da;
        logic       vb;
        logic [7:0] db;
        logic       w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_op;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en_a, rd_en_b;
    logic [2:0] rd_addr_a, rd_addr_b;

    logic [7:0] data_a0, data_b0, data_a1, data_b1;
    logic       valid_a0, valid_b0, valid_a1, valid_b1, wrap0, wrap1;

    int errors = 0;
    int checks = 0;

    int         mem   [2][8];
    logic [7:0] held_a[2];
    logic [7:0] held_b[2];
    int         depth_of[2] = '{8, 6};
    int         zero_of [2] = '{0, 1};

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    cpu_regfile_mp #(.DATA_W(8), .DEPTH(8), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_data_a(data_a0), .rd_valid_a(valid_a0), .rd_en_b(rd_en_b),
        .rd_addr_b(rd_addr_b), .rd_data_b(data_b0), .rd_valid_b(valid_b0),
        .wrap(wrap0)
    );

    cpu_regfile_mp #(.DATA_W(8), .DEPTH(6), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_data_a(data_a1), .rd_valid_a(valid_a1), .rd_en_b(rd_en_b),
        .rd_addr_b(rd_addr_b), .rd_data_b(data_b1), .rd_valid_b(valid_b1),
        .wrap(wrap1)
    );

    function automatic logic [7:0] model_read(input int d, input int addr);
        if (addr >= depth_of[d] || (zero_of[d] != 0 && addr == 0)) return 8'h00;
        return 8'(mem[d][addr]);
    endfunction

    // Registers are updated first, so a read of the written address sees the new value.
    function automatic exp_t model_step(input int d);
        exp_t e;
        int   a;
        int   old;
        e.w = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 8; i++) mem[d][i] = 0;
            held_a[d] = 8'h00;
            held_b[d] = 8'h00;
            e.va = 1'b0; e.vb = 1'b0;
        end else begin
            a = int'(wr_addr);
            if (wr_en && a < depth_of[d] && !(zero_of[d] != 0 && a == 0)) begin
                old = mem[d][a];
                case (wr_op)
                    2'd0: mem[d][a] = int'(wr_data);
                    2'd1: begin mem[d][a] = (old + 1) % 256;   e.w = (old == 255); end
                    2'd2: begin mem[d][a] = (old + 255) % 256; e.w = (old == 0);   end
                    default: mem[d][a] = 0;
                endcase
            end
            if (rd_en_a) held_a[d] = model_read(d, int'(rd_addr_a));
            if (rd_en_b) held_b[d] = model_read(d, int'(rd_addr_b));
            e.va = rd_en_a; e.vb = rd_en_b;
        end
        e.da = held_a[d];
        e.db = held_b[d];
        return e;
    endfunction

    task automatic step(input logic r, input logic we, input logic [1:0] op,
                        input logic [2:0] wa, input logic [7:0] wd,
                        input logic rea, input logic [2:0] ra,
                        input logic reb, input logic [2:0] rb);
        rst = r; wr_en = we; wr_op = op; wr_addr = wa; wr_data = wd;
        rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb;
        @(posedge clk);
        q0.push_back(model_step(0));
        q1.push_back(model_step(1));
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [2:0] wa, input logic [7:0] wd);
        step(1'b1, 1'b1, op, wa, wd, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic rd(input logic rea, input logic [2:0] ra, input logic reb, input logic [2:0] rb);
        step(1'b1, 1'b0, 2'd0, 3'd0, 8'h00, rea, ra, reb, rb);
    endtask

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("rd_valid_a", 0, 8'(valid_a0), 8'(e0.va));
            chk("rd_data_a",  0, data_a0,      e0.da);
            chk("rd_valid_b", 0, 8'(valid_b0), 8'(e0.vb));
            chk("rd_data_b",  0, data_b0,      e0.db);
            chk("wrap",       0, 8'(wrap0),    8'(e0.w));
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("rd_valid_a", 1, 8'(valid_a1), 8'(e1.va));
            chk("rd_data_a",  1, data_a1,      e1.da);
            chk("rd_valid_b", 1, 8'(valid_b1), 8'(e1.vb));
            chk("rd_data_b",  1, data_b1,      e1.db);
            chk("wrap",       1, 8'(wrap1),    8'(e1.w));
        end
    end

    initial begin
        step(1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);

        // Reset discards a prior load
        wr(2'd0, 3'd3, 8'hA5);
        step(1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        rd(1'b1, 3'd3, 1'b0, 3'd0);
        rd(1'b0, 3'd0, 1'b0, 3'd0);

        // Load and dual read
        wr(2'd0, 3'd1, 8'h3C);
        wr(2'd0, 3'd2, 8'hC3);
        rd(1'b1, 3'd1, 1'b1, 3'd2);

        // Same-cycle bypass on both ports, then inc with bypass
        step(1'b1, 1'b1, 2'd0, 3'd5, 8'h77, 1'b1, 3'd5, 1'b1, 3'd5);
        step(1'b1, 1'b1, 2'd1, 3'd5, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0);

        // Wrap on inc and dec, accumulation of back-to-back incs
        wr(2'd0, 3'd4, 8'hFF);
        step(1'b1, 1'b1, 2'd1, 3'd4, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0);
        step(1'b1, 1'b1, 2'd2, 3'd4, 8'h00, 1'b0, 3'd0, 1'b1, 3'd4);
        wr(2'd0, 3'd6, 8'h10);
        wr(2'd1, 3'd6, 8'h00);
        wr(2'd1, 3'd6, 8'h00);
        rd(1'b1, 3'd6, 1'b1, 3'd4);

        // Register 0 and out-of-range addresses
        wr(2'd0, 3'd0, 8'h55);
        rd(1'b1, 3'd0, 1'b0, 3'd0);
        wr(2'd0, 3'd7, 8'h11);
        rd(1'b1, 3'd7, 1'b1, 3'd0);
        for (int i = 1; i < 6; i++) rd(1'b1, 3'(i), 1'b1, 3'(5 - i));

        // Hold with rd_en low, then write lost under reset
        rd(1'b1, 3'd1, 1'b1, 3'd1);
        for (int i = 0; i < 3; i++) rd(1'b0, 3'd2, 1'b0, 3'd3);
        step(1'b0, 1'b1, 2'd0, 3'd1, 8'h99, 1'b1, 3'd1, 1'b0, 3'd0);
        rd(1'b1, 3'd1, 1'b1, 3'd1);

        // Randomized traffic with occasional mid-sequence resets
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] wd;
            wd = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            step(($urandom_range(99) != 0), 1'($urandom), 2'($urandom), 3'($urandom), wd,
                 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
        end

        rd(1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
